mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage, directly downstream of the execute stage.
- Consumes the execute stage's ALU op, write-back register record, and effective RAM address, plus store data.
- Runs a req/ack transaction on the data-RAM port for LB/LW/SB/SW and stalls the pipeline until the access completes.
- Returns the final write-back record to the write-back stage; all other ops pass through with zero latency.

Parameters:
- BIG_ENDIAN, 1, byte-lane ordering: 1 = address offset 0 maps to bits [31:24]; 0 = offset 0 maps to bits [7:0].
- ACK_TIMEOUT, 255, maximum number of ACCESS cycles without ram_ack_i before the access is abandoned; 8-bit counter.

Ports:
- clk  in  1  stage clock, rising edge
- rst  in  1  asynchronous, active-low reset
- mem_alu_i  in  alu_t  op/sel from execute stage
- mem_wreg_i  in  reg_t  en/addr/data from execute stage
- mem_ramaddr_i  in  ram_addr_t  effective address (32b)
- mem_storedata_i  in  32  rt value for SB/SW
- ram_req_o  out  1  data-RAM request
- ram_we_o  out  1  1 = write
- ram_addr_o  out  32  word address; bits [1:0] forced to 0
- ram_sel_o  out  4  byte enables
- ram_wdata_o  out  32  write data
- ram_rdata_i  in  32  read data, valid in the cycle ram_ack_i = 1
- ram_ack_i  in  1  transaction-complete strobe
- mem_wreg_o  out  reg_t  write-back record
- stallreq_from_mem  out  1  freeze upstream stages

Behaviour:
- Reset (rst = 0, asynchronous):
  - FSM returns to IDLE.
  - ram_req_o, ram_we_o, ram_sel_o, ram_wdata_o, and ram_addr_o all go to 0.
  - mem_wreg_o goes to all-zero; stallreq_from_mem goes to 0; timeout counter clears.
  - Reset asserted mid-access abandons the transaction; a late ram_ack_i after reset is ignored.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, non-memory op:
  - mem_wreg_o = mem_wreg_i combinationally; stall = 0.
- IDLE, memory op (LB/LW/SB/SW):
  - stall = 1 combinationally.
  - On the next edge, the address, we, sel, and wdata registers load and the FSM moves to ACCESS.
  - mem_wreg_o.en = 0 while in IDLE.
- ACCESS:
  - ram_req_o = 1; addr, we, sel, and wdata are held stable; stall = 1; mem_wreg_o.en = 0.
  - On ram_ack_i = 1: capture the load result and move to DONE.
  - ram_ack_i seen in IDLE or DONE is ignored.
- DONE:
  - ram_req_o = 0; stall = 0.
  - mem_wreg_o carries the registered result for exactly one cycle, then the FSM moves to IDLE.
  - Stores drive mem_wreg_o.en = 0.
  - Because stall is low, the upstream register advances at the end of DONE, so the same op is never retriggered.
- Byte handling, with lane = addr[1:0] (reversed when BIG_ENDIAN = 1):
  - LB: sel = one-hot lane; result = selected byte sign-extended to 32 bits.
  - SB: sel = one-hot lane; wdata = store byte replicated into all 4 lanes.
  - LW/SW: sel = 4'b1111; result or wdata = full word.
- Timeout:
  - The counter increments each ACCESS cycle without an ack.
  - When the count reaches ACK_TIMEOUT: drop the request, go to DONE with mem_wreg_o.en = 0 (a load writes nothing), and release the stall.
- Simultaneous events: an ack arriving in the same cycle the counter reaches ACK_TIMEOUT is treated as a success.
- Latency: a memory op occupies at least 3 cycles (IDLE detect, ACCESS with a 1-cycle ack, DONE).

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - Adds output mem_misalign_o (1 bit).
  - An LW/SW with addr[1:0] != 0 is detected in IDLE and never issues a request.
  - The FSM goes straight to DONE with mem_wreg_o.en = 0 and mem_misalign_o = 1 for that DONE cycle only.
- Undefined: the port is absent; misaligned words proceed with addr[1:0] masked to 0.

Decomposition:
- The shared project_types package gets mem_state_t (IDLE/ACCESS/DONE) and the byte_sel_t (4b) typedef.
- The decode_table package already owns LB_OP/LW_OP/SB_OP/SW_OP; add the is_mem_op() function there.
- Sub-module mem_lane_align: combinational byte-lane select/replicate and sign-extension, parameterised by BIG_ENDIAN. It is reused by the write-back path for future LH/LBU support.

Test Plan:
- OR_OP passthrough, wreg = {en=1, addr=5, data=32'h0000_00FF} -> same record on mem_wreg_o in the same cycle; stall = 0; ram_req_o = 0.
- LW at 32'h100 with ack 1 cycle after req, rdata = 32'hDEAD_BEEF:
  - stall high for 2 cycles;
  - DONE cycle shows wreg.data = 32'hDEAD_BEEF and en = 1;
  - then IDLE.
- LB at 32'h103, BIG_ENDIAN = 1, rdata = 32'h1122_3380:
  - sel = 4'b0001;
  - wreg.data = 32'hFFFF_FF80.
- SB at 32'h201 with storedata = 32'h0000_00AB, BIG_ENDIAN = 1:
  - we = 1, sel = 4'b0100, wdata = 32'hABAB_ABAB, addr = 32'h200;
  - mem_wreg_o.en = 0 in DONE.
- LW with no ack, ACK_TIMEOUT = 4:
  - req drops after 4 ACCESS cycles;
  - DONE with en = 0, then IDLE.
- rst pulled low during ACCESS, then a stray ack -> all outputs 0 immediately; the ack is ignored after release.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types, decode constants and helpers for the memory-access pipeline stage.
package mem_stage_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ALU_OP_W   = 8;
    localparam int unsigned ALU_SEL_W  = 3;
    localparam int unsigned CNT_W      = 8;

    typedef logic [DATA_W-1:0] ram_addr_t;
    typedef logic [3:0]        byte_sel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    typedef struct packed {
        logic [ALU_OP_W-1:0]  op;
        logic [ALU_SEL_W-1:0] sel;
    } alu_t;

    typedef struct packed {
        logic                  en;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } reg_t;

    localparam logic [ALU_SEL_W-1:0] SEL_NOP       = 3'b000;
    localparam logic [ALU_SEL_W-1:0] SEL_LOGIC     = 3'b001;
    localparam logic [ALU_SEL_W-1:0] SEL_LOADSTORE = 3'b111;

    localparam logic [ALU_OP_W-1:0] OR_OP = 8'b0010_0101;
    localparam logic [ALU_OP_W-1:0] LB_OP = 8'b1110_0000;
    localparam logic [ALU_OP_W-1:0] LW_OP = 8'b1110_0011;
    localparam logic [ALU_OP_W-1:0] SB_OP = 8'b1110_1000;
    localparam logic [ALU_OP_W-1:0] SW_OP = 8'b1110_1011;

    function automatic logic is_mem_op(input alu_t a);
        return (a.sel == SEL_LOADSTORE) && (a.op inside {LB_OP, LW_OP, SB_OP, SW_OP});
    endfunction

    function automatic logic is_word_op(input alu_t a);
        return (a.op == LW_OP) || (a.op == SW_OP);
    endfunction

    function automatic logic is_store_op(input alu_t a);
        return (a.op == SB_OP) || (a.op == SW_OP);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane enable/replication for stores and lane select plus sign-extension for loads.
module mem_lane_align
    import mem_stage_pkg::*;
#(
    parameter int unsigned BIG_ENDIAN = 1
) (
    input  logic [1:0]        offset,
    input  logic              word,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] load_data,
    output byte_sel_t         sel,
    output logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [1:0] lane;
    logic [7:0] ld_byte;

    always_comb begin
        // big-endian puts offset 0 in the top byte, i.e. lane = 3 - offset
        lane    = (BIG_ENDIAN != 0) ? ~offset : offset;
        ld_byte = load_data[{lane, 3'b000} +: 8];
        sel     = word ? 4'b1111 : byte_sel_t'(4'b0001 << lane);
        wdata   = word ? store_data : {4{store_data[7:0]}};
        rdata   = word ? load_data : {{24{ld_byte[7]}}, ld_byte};
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: req/ack data-RAM transaction with stall and timeout.
// Optional MEM_ALIGN_CHECK_EN: reject misaligned LW/SW and flag them on mem_misalign_o.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned BIG_ENDIAN  = 1,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  alu_t              mem_alu_i,
    input  reg_t              mem_wreg_i,
    input  ram_addr_t         mem_ramaddr_i,
    input  logic [DATA_W-1:0] mem_storedata_i,
    output logic              ram_req_o,
    output logic              ram_we_o,
    output logic [DATA_W-1:0] ram_addr_o,
    output byte_sel_t         ram_sel_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    input  logic              ram_ack_i,
`ifdef MEM_ALIGN_CHECK_EN
    output logic              mem_misalign_o,
`endif
    output reg_t              mem_wreg_o,
    output logic              stallreq_from_mem
);

    mem_state_t            state_q, state_d;
    ram_addr_t             addr_q;
    logic                  we_q;
    byte_sel_t             sel_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [1:0]            off_q;
    logic                  word_q;
    logic                  ld_en_q;
    logic [REG_ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0]     result_q;
    logic                  res_en_q;
    logic [CNT_W-1:0]      cnt_q;

    logic load_c, capture_c, timeout_c, mem_op_c;
    logic [1:0]        al_off;
    logic              al_word;
    byte_sel_t         al_sel;
    logic [DATA_W-1:0] al_wdata, al_rdata;

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_c, misalign_q;
    assign mem_misalign_o = (state_q == DONE) && misalign_q;
`endif

    assign mem_op_c = is_mem_op(mem_alu_i);

    // aligner sees the incoming op while idle, the captured access afterwards
    assign al_off  = (state_q == IDLE) ? mem_ramaddr_i[1:0] : off_q;
    assign al_word = (state_q == IDLE) ? is_word_op(mem_alu_i) : word_q;

    mem_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
        .offset     (al_off),
        .word       (al_word),
        .store_data (mem_storedata_i),
        .load_data  (ram_rdata_i),
        .sel        (al_sel),
        .wdata      (al_wdata),
        .rdata      (al_rdata)
    );

    assign ram_req_o   = (state_q == ACCESS);
    assign ram_we_o    = we_q;
    assign ram_addr_o  = addr_q;
    assign ram_sel_o   = sel_q;
    assign ram_wdata_o = wdata_q;

    always_comb begin
        state_d           = state_q;
        load_c            = 1'b0;
        capture_c         = 1'b0;
        timeout_c         = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        misalign_c        = 1'b0;
`endif
        stallreq_from_mem = 1'b0;
        mem_wreg_o        = mem_wreg_i;
        case (state_q)
            IDLE: begin
                if (mem_op_c) begin
                    stallreq_from_mem = 1'b1;
                    mem_wreg_o.en     = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                    if (is_word_op(mem_alu_i) && (mem_ramaddr_i[1:0] != 2'b00)) begin
                        misalign_c = 1'b1;
                        state_d    = DONE;
                    end else begin
                        load_c  = 1'b1;
                        state_d = ACCESS;
                    end
`else
                    load_c  = 1'b1;
                    state_d = ACCESS;
`endif
                end
            end
            ACCESS: begin
                stallreq_from_mem = 1'b1;
                mem_wreg_o.en     = 1'b0;
                // an ack on the final allowed cycle still counts as success
                if (ram_ack_i) begin
                    capture_c = 1'b1;
                    state_d   = DONE;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    timeout_c = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                mem_wreg_o = '{en: res_en_q, addr: waddr_q, data: result_q};
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (!rst) begin
            mem_wreg_o        = '0;
            stallreq_from_mem = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            wdata_q  <= '0;
            off_q    <= '0;
            word_q   <= 1'b0;
            ld_en_q  <= 1'b0;
            waddr_q  <= '0;
            result_q <= '0;
            res_en_q <= 1'b0;
            cnt_q    <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (load_c) begin
                addr_q  <= {mem_ramaddr_i[DATA_W-1:2], 2'b00};
                we_q    <= is_store_op(mem_alu_i);
                sel_q   <= al_sel;
                wdata_q <= al_wdata;
                off_q   <= mem_ramaddr_i[1:0];
                word_q  <= is_word_op(mem_alu_i);
                ld_en_q <= mem_wreg_i.en & ~is_store_op(mem_alu_i);
                waddr_q <= mem_wreg_i.addr;
                cnt_q   <= '0;
            end else if (state_q == ACCESS && !ram_ack_i && !timeout_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (capture_c) begin
                result_q <= al_rdata;
                res_en_q <= ld_en_q;
            end
            if (timeout_c) begin
                res_en_q <= 1'b0;
            end
`ifdef MEM_ALIGN_CHECK_EN
            if (misalign_c) begin
                res_en_q <= 1'b0;
                waddr_q  <= mem_wreg_i.addr;
            end
            if (load_c || misalign_c) begin
                misalign_q <= misalign_c;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (BIG_ENDIAN = 1, ACK_TIMEOUT = 4).
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk, rst;
    alu_t        alu_i;
    reg_t        wreg_i, wreg_o;
    ram_addr_t   raddr_i;
    logic [31:0] sdata, rdata, ram_addr, ram_wdata;
    logic        req, we, ack, stall;
    byte_sel_t   sel;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int passed = 0;
    int total  = 0;

    mem_stage #(.BIG_ENDIAN(1), .ACK_TIMEOUT(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_alu_i         (alu_i),
        .mem_wreg_i        (wreg_i),
        .mem_ramaddr_i     (raddr_i),
        .mem_storedata_i   (sdata),
        .ram_req_o         (req),
        .ram_we_o          (we),
        .ram_addr_o        (ram_addr),
        .ram_sel_o         (sel),
        .ram_wdata_o       (ram_wdata),
        .ram_rdata_i       (rdata),
        .ram_ack_i         (ack),
`ifdef MEM_ALIGN_CHECK_EN
        .mem_misalign_o    (misalign),
`endif
        .mem_wreg_o        (wreg_o),
        .stallreq_from_mem (stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] s, input reg_t w,
                         input logic [31:0] a, input logic [31:0] d);
        alu_i   = '{op: op, sel: s};
        wreg_i  = w;
        raddr_i = a;
        sdata   = d;
    endtask

    reg_t or_rec;

    initial begin
        or_rec = '{en: 1'b1, addr: 5'd5, data: 32'h0000_00FF};
        rst = 1'b0; ack = 1'b0; rdata = '0;
        drive(OR_OP, SEL_LOGIC, or_rec, 32'h0, 32'h0);
        #1;
        chk("rst_req", 64'(req), 64'(0));
        chk("rst_wreg", 64'(wreg_o), 64'(0));
        chk("rst_stall", 64'(stall), 64'(0));
        chk("rst_addr", 64'(ram_addr), 64'(0));
        #11 rst = 1'b1;
        step();

        // passthrough
        #1;
        chk("or_wreg", 64'(wreg_o), 64'(or_rec));
        chk("or_stall", 64'(stall), 64'(0));
        chk("or_req", 64'(req), 64'(0));

        // LW with single-cycle ack
        drive(LW_OP, SEL_LOADSTORE, '{en: 1'b1, addr: 5'd3, data: 32'h0}, 32'h100, 32'h0);
        #1;
        chk("lw_det_stall", 64'(stall), 64'(1));
        chk("lw_det_en", 64'(wreg_o.en), 64'(0));
        chk("lw_det_req", 64'(req), 64'(0));
        step();
        chk("lw_acc_req", 64'(req), 64'(1));
        chk("lw_acc_stall", 64'(stall), 64'(1));
        chk("lw_acc_addr", 64'(ram_addr), 64'h100);
        chk("lw_acc_sel", 64'(sel), 64'hF);
        chk("lw_acc_we", 64'(we), 64'(0));
        ack = 1'b1; rdata = 32'hDEAD_BEEF;
        step();
        ack = 1'b0; rdata = '0;
        #1;
        chk("lw_done_stall", 64'(stall), 64'(0));
        chk("lw_done_req", 64'(req), 64'(0));
        chk("lw_done_wreg", 64'(wreg_o), 64'({1'b1, 5'd3, 32'hDEAD_BEEF}));
        step();
        drive(OR_OP, SEL_LOGIC, or_rec, 32'h0, 32'h0);
        #1;
        chk("lw_idle_wreg", 64'(wreg_o), 64'(or_rec));

        // LB big-endian at offset 3
        drive(LB_OP, SEL_LOADSTORE, '{en: 1'b1, addr: 5'd7, data: 32'h0}, 32'h103, 32'h0);
        step();
        chk("lb_acc_sel", 64'(sel), 64'h1);
        chk("lb_acc_addr", 64'(ram_addr), 64'h100);
        ack = 1'b1; rdata = 32'h1122_3380;
        step();
        ack = 1'b0; rdata = '0;
        #1;
        chk("lb_done_wreg", 64'(wreg_o), 64'({1'b1, 5'd7, 32'hFFFF_FF80}));
        step();

        // SB big-endian at offset 1
        drive(SB_OP, SEL_LOADSTORE, '{en: 1'b0, addr: 5'd0, data: 32'h0}, 32'h201, 32'h0000_00AB);
        step();
        chk("sb_we", 64'(we), 64'(1));
        chk("sb_sel", 64'(sel), 64'h4);
        chk("sb_wdata", 64'(ram_wdata), 64'hABAB_ABAB);
        chk("sb_addr", 64'(ram_addr), 64'h200);
        ack = 1'b1;
        step();
        ack = 1'b0;
        #1;
        chk("sb_done_en", 64'(wreg_o.en), 64'(0));
        chk("sb_done_stall", 64'(stall), 64'(0));
        step();

        // LW timeout: no ack
        drive(LW_OP, SEL_LOADSTORE, '{en: 1'b1, addr: 5'd9, data: 32'h0}, 32'h300, 32'h0);
        step();
        begin
            int n = 0;
            for (int i = 0; i < 10; i++) begin
                if (!req) break;
                n++;
                step();
            end
            chk("to_access_cycles", 64'(n), 64'(4));
        end
        #1;
        chk("to_done_req", 64'(req), 64'(0));
        chk("to_done_en", 64'(wreg_o.en), 64'(0));
        chk("to_done_stall", 64'(stall), 64'(0));
        step();
        drive(OR_OP, SEL_LOGIC, or_rec, 32'h0, 32'h0);
        #1;
        chk("to_idle_wreg", 64'(wreg_o), 64'(or_rec));

        // ack on the last allowed ACCESS cycle wins; misaligned LW masks addr
        drive(LW_OP, SEL_LOADSTORE, '{en: 1'b1, addr: 5'd4, data: 32'h0}, 32'h506, 32'h0);
        step();
        chk("edge_addr", 64'(ram_addr), 64'h504);
        for (int i = 0; i < 3; i++) step();
        chk("edge_req4", 64'(req), 64'(1));
        ack = 1'b1; rdata = 32'h1234_5678;
        step();
        ack = 1'b0; rdata = '0;
        #1;
        chk("edge_done_wreg", 64'(wreg_o), 64'({1'b1, 5'd4, 32'h1234_5678}));
        step();

        // reset during ACCESS, then a stray ack
        drive(SW_OP, SEL_LOADSTORE, '{en: 1'b0, addr: 5'd0, data: 32'h0}, 32'h400, 32'hCAFE_F00D);
        step();
        chk("rm_req_before", 64'(req), 64'(1));
        #2 rst = 1'b0;
        #1;
        chk("rm_req", 64'(req), 64'(0));
        chk("rm_we", 64'(we), 64'(0));
        chk("rm_addr", 64'(ram_addr), 64'(0));
        chk("rm_sel", 64'(sel), 64'(0));
        chk("rm_wdata", 64'(ram_wdata), 64'(0));
        chk("rm_wreg", 64'(wreg_o), 64'(0));
        chk("rm_stall", 64'(stall), 64'(0));
        drive(OR_OP, SEL_LOGIC, or_rec, 32'h0, 32'h0);
        ack = 1'b1;
        step();
        rst = 1'b1;
        step();
        chk("stray_req", 64'(req), 64'(0));
        chk("stray_wreg", 64'(wreg_o), 64'(or_rec));
        step();
        chk("stray_wreg2", 64'(wreg_o), 64'(or_rec));
        chk("stray_stall", 64'(stall), 64'(0));
        ack = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
